error_stage: RTL
================

// Module: error_stage
// PURPOSE
//   Sits directly downstream of the forward-propagation sigmoid stage; that stage produces
//   ycap, one Q1.8 activation per sample.
//   Collects one batch of ycap values together with their 1-bit labels.
//   Per sample, computes err = ycap - label in Q1.8 and buffers it.
//   Accumulates sum|err| for the batch; squared-error sum is optional (see CONFIGURATION).
//   Drains the buffered errors over a valid/ready stream to the gradient/weight-update stage.
// PARAMETERS
//   NUM_SAMPLES  40  batch size; also the number of columns the sigmoid stage produces
//   IDX_W        6   width of sample index; must satisfy 2**IDX_W >= NUM_SAMPLES
// PORTS
//   clk           in   1      single clock; all state changes on posedge
//   rst           in   1      synchronous, active-high reset
//   start         in   1      1-cycle pulse; begins a batch; ignored unless state==IDLE
//   in_valid      in   1      ycap/label sample present
//   in_ready      out  1      sample accepted when in_valid && in_ready
//   in_ycap       in   10     signed Q1.8 activation from sigmoid stage
//   in_label      in   1      target value: 0 -> 0.0, 1 -> 1.0 (256 in Q1.8)
//   out_valid     out  1      buffered error present
//   out_ready     in   1      downstream accepts error when out_valid && out_ready
//   out_err       out  10     signed Q1.8 error, range -256..+256
//   out_idx       out  IDX_W  sample index of out_err
//   done          out  1      1-cycle pulse after last error is drained
//   abs_err_sum   out  14     unsigned sum|err| of the batch (Q6.8)
//   sq_err_sum    out  22     unsigned sum err^2 (Q6.16); tied 0 without ERR_STAGE_MSE_EN
// BEHAVIOUR
//   Reset (rst=1 at posedge):
//     state=IDLE; wr_idx=rd_idx=0.
//     in_ready=0, out_valid=0, out_err=0, out_idx=0, done=0, abs_err_sum=0, sq_err_sum=0.
//     Reset mid-batch discards the batch; buffer contents become don't-care.
//   FSM: IDLE -> COLLECT -> DRAIN -> DONE -> IDLE
//   IDLE:
//     in_ready=0, out_valid=0.
//     On start: clear both sums and wr_idx, go to COLLECT next cycle.
//     The sums otherwise hold the last batch's results.
//   COLLECT:
//     in_ready=1 (combinational from state).
//     On accept:
//       - clamp in_ycap: value <0 -> 0, value >256 -> 256;
//       - err = clamp - (in_label ? 256 : 0);
//       - buf[wr_idx] <= err; abs_err_sum += |err|; wr_idx++.
//     Accept on wr_idx==NUM_SAMPLES-1: go to DRAIN next cycle; in_ready=0 that cycle.
//     No bubbles required: back-to-back accepts every cycle.
//   DRAIN:
//     out_valid=1, out_err=buf[rd_idx], out_idx=rd_idx; both held stable while stalled.
//     On out_ready: rd_idx++.
//     Transfer of index NUM_SAMPLES-1: go to DONE, rd_idx=0.
//   DONE:
//     done=1 for exactly one cycle, out_valid=0, then IDLE.
//     start in the DONE cycle is ignored.
//   Latency:
//     - first out_valid is 1 cycle after the last input accept;
//     - done is 1 cycle after the last output transfer;
//     - minimum batch = 1 (start) + N (collect) + N (drain) + 1 (done) cycles.
//   Sums are final when done pulses and stay stable until the next start.
//   Widths guarantee no overflow: 40*256=10240 < 2^14; 40*65536 < 2^22.
//   in_valid outside COLLECT and out_ready outside DRAIN are ignored.
// CONFIGURATION
//   ERR_STAGE_MSE_EN defined:
//     10x10 squarer; on each accept sq_err_sum += err*err (17-bit product, zero-extended).
//   ERR_STAGE_MSE_EN undefined:
//     no multiplier; sq_err_sum is constant 0.
//   All other behaviour is identical in both builds.
// STRUCTURE
//   nn_pkg holds the shared constants:
//     - Q_FRAC=8, ONE_Q8=10'd256, NUM_SAMPLES=40, IDX_W=6;
//     - FSM state encoding (IDLE/COLLECT/DRAIN/DONE, 2 bits).
//   One sub-module, err_buffer: NUM_SAMPLES x 10 register file with 1 write and 1 async read port.
//   Clamp, subtract and accumulate logic stay in error_stage.
// TESTING
//   T1: rst mid-DRAIN at idx 17.
//       -> next cycle IDLE, out_valid=0, sums=0, in_ready=0; a new start runs a clean batch.
//   T2: start, 40 samples ycap=192 label=1, out_ready=1.
//       -> each out_err=-64, out_idx 0..39; abs_err_sum=2560; sq_err_sum=163840 (MSE build).
//   T3: ycap=-5 label=0 and ycap=300 label=1 (clamp checks).
//       -> err 0 and 0 at the respective idx; no sum contribution.
//   T4: random in_valid gaps plus out_ready held low 5 cycles at idx 3.
//       -> out_err/out_idx stable through the stall; no sample lost or duplicated (scoreboard).
//   T5: start asserted during COLLECT, DRAIN and DONE.
//       -> ignored; wr_idx/rd_idx/sums unaffected; exactly one done per batch.
//   T6: MSE build undefined, data as T2.
//       -> sq_err_sum=0, abs_err_sum=2560, timing identical.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants, types and helpers for the error stage.
//   Q_FRAC, ONE_Q8   : Q1.8 fixed-point format (1.0 == 256)
//   NUM_SAMPLES      : batch size
//   IDX_W            : sample index width (2**IDX_W >= NUM_SAMPLES)
//   state_t          : error_stage FSM encoding
//   calc_err         : clamp ycap to [0,1.0] and subtract the label
package nn_pkg;

   localparam int          Q_FRAC      = 8;
   localparam logic [9:0]  ONE_Q8      = 10'(1 << Q_FRAC);
   localparam int          NUM_SAMPLES = 40;
   localparam int          IDX_W       = 6;
   localparam int          ERR_W       = 10;
   localparam int          ABS_W       = 14;
   localparam int          SQ_W        = 22;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Sigmoid output can slightly overshoot [0,1] after rounding; clamp first
   // so the error always lies in -256..+256.
   function automatic logic signed [ERR_W-1:0] calc_err(
      input logic signed [ERR_W-1:0] ycap,
      input logic                    label
   );
      logic signed [ERR_W-1:0] c;
      if (ycap < 0)
         c = '0;
      else if (ycap > $signed(ONE_Q8))
         c = $signed(ONE_Q8);
      else
         c = ycap;
      return label ? (c - $signed(ONE_Q8)) : c;
   endfunction

endpackage

// File: rtl/error_stage_if.sv
// Stream interface of the error stage.
//   Input stream : in_valid/in_ready, in_ycap (signed Q1.8), in_label
//   Output stream: out_valid/out_ready, out_err (signed Q1.8), out_idx
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; the sender holds its payload stable while valid && !ready.
// Modports: slave = error stage side, master = upstream/downstream side.
interface error_stage_if
   import nn_pkg::*;
();

   logic                     in_valid;
   logic                     in_ready;
   logic signed [ERR_W-1:0]  in_ycap;
   logic                     in_label;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ERR_W-1:0]  out_err;
   logic [IDX_W-1:0]         out_idx;

   modport slave (
      input  in_valid, in_ycap, in_label, out_ready,
      output in_ready, out_valid, out_err, out_idx
   );

   modport master (
      output in_valid, in_ycap, in_label, out_ready,
      input  in_ready, out_valid, out_err, out_idx
   );

endinterface

// File: rtl/error_stage_err_buffer.sv
// err_buffer: DEPTH x DW register file, one synchronous write port and one
// asynchronous read port. Contents are not reset; every entry is written
// during COLLECT before it is read during DRAIN.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module err_buffer
   import nn_pkg::*;
#(
   parameter int DEPTH = NUM_SAMPLES,
   parameter int AW    = IDX_W,
   parameter int DW    = ERR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/error_stage.sv
// error_stage: collects one batch of sigmoid outputs (ycap) with labels,
// computes err = clamp(ycap) - label per sample, buffers the errors, sums
// |err| (and optionally err^2), then drains the errors to the gradient stage.
// Optional feature macro: ERR_STAGE_MSE_EN enables the squared-error sum.
//   clk, rst      : clock, synchronous active-high reset
//   start         : 1-cycle pulse, begins a batch (only honoured in IDLE)
//   bus           : error_stage_if.slave (input and output streams)
//   done          : 1-cycle pulse after the last error is drained
//   abs_err_sum   : sum |err| of the batch, unsigned Q6.8
//   sq_err_sum    : sum err^2 of the batch, unsigned Q6.16 (0 without MSE)
//   dbg_state     : current FSM state
module error_stage
   import nn_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   error_stage_if.slave      bus,
   output logic              done,
   output logic [ABS_W-1:0]  abs_err_sum,
   output logic [SQ_W-1:0]   sq_err_sum,
   output state_t            dbg_state
);

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
   logic [ABS_W-1:0]         abs_sum_q, abs_sum_d;

   logic                     accept;
   logic                     start_ok;
   logic signed [ERR_W-1:0]  err;
   logic [ERR_W-1:0]         err_mag;
   logic [ERR_W-1:0]         rd_data;

   assign start_ok = (state_q == IDLE) && start;
   assign accept   = (state_q == COLLECT) && bus.in_valid;
   assign err      = calc_err(bus.in_ycap, bus.in_label);
   // |err| <= 256, so negating a negative err never overflows 10 bits
   assign err_mag  = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);

   err_buffer #(
      .DEPTH (NUM_SAMPLES),
      .AW    (IDX_W),
      .DW    (ERR_W)
   ) u_err_buffer (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_idx_q),
      .wdata (err),
      .raddr (rd_idx_q),
      .rdata (rd_data)
   );

   always_comb begin
      state_d   = state_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      abs_sum_d = abs_sum_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = COLLECT;
               wr_idx_d  = '0;
               abs_sum_d = '0;
            end
         end
         COLLECT: begin
            if (accept) begin
               wr_idx_d  = wr_idx_q + 1'b1;
               abs_sum_d = abs_sum_q + ABS_W'(err_mag);
               if (wr_idx_q == IDX_W'(NUM_SAMPLES - 1))
                  state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               rd_idx_d = rd_idx_q + 1'b1;
               if (rd_idx_q == IDX_W'(NUM_SAMPLES - 1)) begin
                  rd_idx_d = '0;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         abs_sum_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         abs_sum_q <= abs_sum_d;
      end
   end

`ifdef ERR_STAGE_MSE_EN
   logic [SQ_W-1:0] sq_sum_q, sq_sum_d;
   logic [16:0]     err_sq;

   // Squaring the magnitude gives err^2 without a signed multiplier; the
   // largest value, 256*256, needs exactly 17 bits.
   assign err_sq = 17'(err_mag * err_mag);

   always_comb begin
      sq_sum_d = sq_sum_q;
      if (start_ok)
         sq_sum_d = '0;
      else if (accept)
         sq_sum_d = sq_sum_q + SQ_W'(err_sq);
   end

   always_ff @(posedge clk) begin
      if (rst)
         sq_sum_q <= '0;
      else
         sq_sum_q <= sq_sum_d;
   end

   assign sq_err_sum = sq_sum_q;
`else
   assign sq_err_sum = '0;
`endif

   assign bus.in_ready  = (state_q == COLLECT);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.out_err   = (state_q == DRAIN) ? $signed(rd_data) : '0;
   assign bus.out_idx   = rd_idx_q;
   assign done          = (state_q == DONE);
   assign abs_err_sum   = abs_sum_q;
   assign dbg_state     = state_q;

endmodule
